// File: rtl/io_poll_pkg.sv
// Shared definitions for the polled multi-channel I/O bus master:
// sequencer state codes, read-phase flag and bus timing constants.
package io_poll_pkg;

    // Sequencer state codes
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RSETUP  = 4'd1;
    localparam logic [3:0] ST_RSTB1   = 4'd2;
    localparam logic [3:0] ST_RSTB2   = 4'd3;
    localparam logic [3:0] ST_RREC    = 4'd4;
    localparam logic [3:0] ST_COMPUTE = 4'd5;
    localparam logic [3:0] ST_WSETUP  = 4'd6;
    localparam logic [3:0] ST_WSTB    = 4'd7;
    localparam logic [3:0] ST_WHOLD   = 4'd8;
    localparam logic [3:0] ST_NEXT    = 4'd9;

    typedef logic [3:0] state_t;

    // Which port the current read cycle targets
    typedef enum logic {
        PH_STAT = 1'b0,
        PH_DATA = 1'b1
    } rphase_e;

    // Width of the output word index (up to 16 product words)
    localparam int WIDX_W = 4;

    // Bus cycle lengths in clocks
    localparam int READ_CLKS  = 4;
    localparam int WRITE_CLKS = 3;

endpackage

// File: rtl/io_poll_mul_ch_const_mul.sv
// Combinational multiply by a constant: shift-add over the set bits of K.
module const_mul #(
    parameter int DATA_W = 8,
    parameter int K      = 5,
    parameter int OUT_W  = 16
) (
    input  logic [DATA_W-1:0] x,
    output logic [OUT_W-1:0]  p
);

    localparam logic [DATA_W-1:0] K_BITS = DATA_W'(K);

    // Accumulate x shifted by each set bit position of K
    always_comb begin
        p = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (K_BITS[i]) begin
                p = p + (OUT_W'(x) << i);
            end else begin
                p = p;
            end
        end
    end

endmodule

// File: rtl/io_poll_mul_ch.sv
// Polled I/O bus master: round-robins over NCH channels, waits for each
// channel's ready bit (with optional timeout skip), reads one word, and
// writes word*K to the channel's output port MSB word first.
module io_poll_mul_ch
    import io_poll_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 16,
    parameter int              NCH       = 2,
    parameter int              K         = 5,
    parameter logic [ADDR_W-1:0] STAT_BASE = 16'h0100,
    parameter logic [ADDR_W-1:0] OUT_BASE  = 16'h0121,
    parameter int              RDY_BIT   = 0,
    parameter int              MAX_POLL  = 16,
    parameter int              RES_BYTES = 2,
    localparam int             CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              ior_,
    output logic              iow_,
    output logic              busy,
    output logic [CH_W-1:0]   cur_ch,
    output logic [15:0]       xfer_cnt,
    output logic [15:0]       skip_cnt
);

    localparam int RES_W = RES_BYTES * DATA_W;

    state_t              state_r;
    rphase_e             phase_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                ior_r;
    logic                iow_r;
    logic                oe_r;
    logic [DATA_W-1:0]   data_out_r;
    logic                busy_r;
    logic [CH_W-1:0]     cur_ch_r;
    logic [15:0]         xfer_cnt_r;
    logic [15:0]         skip_cnt_r;
    logic [15:0]         poll_cnt_r;
    logic [DATA_W-1:0]   rd_r;
    logic [RES_W-1:0]    prod_r;
    logic [WIDX_W-1:0]   widx_r;

    logic [CH_W-1:0]     nxt_ch_s;
    logic [ADDR_W-1:0]   stat_addr_s;
    logic [ADDR_W-1:0]   nxt_stat_addr_s;
    logic [ADDR_W-1:0]   out_addr_s;
    logic                poll_more_s;
    logic                last_word_s;
    logic [RES_W-1:0]    mul_s;

    const_mul #(
        .DATA_W (DATA_W),
        .K      (K),
        .OUT_W  (RES_W)
    ) u_mul (
        .x (rd_r),
        .p (mul_s)
    );

    // Channel advance, port addresses and poll/word decisions
    always_comb begin
        if (cur_ch_r == CH_W'(NCH - 1)) begin
            nxt_ch_s = CH_W'(0);
        end else begin
            nxt_ch_s = cur_ch_r + CH_W'(1);
        end
        stat_addr_s     = STAT_BASE + ADDR_W'({cur_ch_r, 1'b0});
        nxt_stat_addr_s = STAT_BASE + ADDR_W'({nxt_ch_s, 1'b0});
        out_addr_s      = OUT_BASE + ADDR_W'(cur_ch_r);
        poll_more_s     = (MAX_POLL == 0) || (int'(poll_cnt_r) < (MAX_POLL - 1));
        last_word_s     = (widx_r == WIDX_W'(RES_BYTES - 1));
    end

    // Bus sequencer: state, registered bus outputs and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            phase_r    <= PH_STAT;
            addr_r     <= '0;
            ior_r      <= 1'b1;
            iow_r      <= 1'b1;
            oe_r       <= 1'b0;
            data_out_r <= '0;
            busy_r     <= 1'b0;
            cur_ch_r   <= '0;
            xfer_cnt_r <= 16'd0;
            skip_cnt_r <= 16'd0;
            poll_cnt_r <= 16'd0;
            rd_r       <= '0;
            prod_r     <= '0;
            widx_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r <= ST_RSETUP;
                        phase_r <= PH_STAT;
                        addr_r  <= stat_addr_s;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RSETUP: begin
                    state_r <= ST_RSTB1;
                    ior_r   <= 1'b0;
                end
                ST_RSTB1: begin
                    state_r <= ST_RSTB2;
                end
                ST_RSTB2: begin
                    // Data is captured as the strobe is released
                    state_r <= ST_RREC;
                    ior_r   <= 1'b1;
                    rd_r    <= data;
                end
                ST_RREC: begin
                    if (phase_r == PH_DATA) begin
                        state_r <= ST_COMPUTE;
                    end else if (rd_r[RDY_BIT]) begin
                        state_r <= ST_RSETUP;
                        phase_r <= PH_DATA;
                        addr_r  <= stat_addr_s + ADDR_W'(1);
                    end else if (poll_more_s) begin
                        state_r    <= ST_RSETUP;
                        poll_cnt_r <= poll_cnt_r + 16'd1;
                    end else begin
                        state_r    <= ST_NEXT;
                        skip_cnt_r <= skip_cnt_r + 16'd1;
                    end
                end
                ST_COMPUTE: begin
                    // Product is latched here; the top word goes out first
                    state_r    <= ST_WSETUP;
                    addr_r     <= out_addr_s;
                    data_out_r <= mul_s[RES_W-1 -: DATA_W];
                    prod_r     <= mul_s << DATA_W;
                    oe_r       <= 1'b1;
                    widx_r     <= '0;
                end
                ST_WSETUP: begin
                    state_r <= ST_WSTB;
                    iow_r   <= 1'b0;
                end
                ST_WSTB: begin
                    state_r <= ST_WHOLD;
                    iow_r   <= 1'b1;
                end
                ST_WHOLD: begin
                    if (last_word_s) begin
                        state_r    <= ST_NEXT;
                        oe_r       <= 1'b0;
                        xfer_cnt_r <= xfer_cnt_r + 16'd1;
                    end else begin
                        state_r    <= ST_WSETUP;
                        widx_r     <= widx_r + WIDX_W'(1);
                        data_out_r <= prod_r[RES_W-1 -: DATA_W];
                        prod_r     <= prod_r << DATA_W;
                    end
                end
                ST_NEXT: begin
                    poll_cnt_r <= 16'd0;
                    cur_ch_r   <= nxt_ch_s;
                    if (en) begin
                        state_r <= ST_RSETUP;
                        phase_r <= PH_STAT;
                        addr_r  <= nxt_stat_addr_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ior_r   <= 1'b1;
                    iow_r   <= 1'b1;
                    oe_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign addr     = addr_r;
    assign data     = oe_r ? data_out_r : {DATA_W{1'bz}};
    assign ior_     = ior_r;
    assign iow_     = iow_r;
    assign busy     = busy_r;
    assign cur_ch   = cur_ch_r;
    assign xfer_cnt = xfer_cnt_r;
    assign skip_cnt = skip_cnt_r;

endmodule

// File: tb/tb_io_poll_mul_ch.sv
// Bench for io_poll_mul_ch: device model on the I/O bus, bus monitors and a
// transaction-level reference of the expected reads, writes and counters.
module tb_io_poll_mul_ch;

    localparam int NCH      = 3;
    localparam int K        = 5;
    localparam int MAX_POLL = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic [15:0] addr;
    wire  [7:0]  data;
    logic        ior_, iow_, busy;
    logic [1:0]  cur_ch;
    logic [15:0] xfer_cnt, skip_cnt;

    logic        en2 = 1'b0;
    logic [15:0] addr2;
    wire  [7:0]  data2;
    logic        ior2_, iow2_, busy2;
    logic [0:0]  cur_ch2;
    logic [15:0] xfer2, skip2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    io_poll_mul_ch #(.NCH(NCH), .K(K), .MAX_POLL(MAX_POLL)) dut (
        .clock(clock), .reset(reset), .en(en), .addr(addr), .data(data),
        .ior_(ior_), .iow_(iow_), .busy(busy), .cur_ch(cur_ch),
        .xfer_cnt(xfer_cnt), .skip_cnt(skip_cnt));

    io_poll_mul_ch #(.NCH(1), .K(255), .MAX_POLL(0)) dut2 (
        .clock(clock), .reset(reset), .en(en2), .addr(addr2), .data(data2),
        .ior_(ior2_), .iow_(iow2_), .busy(busy2), .cur_ch(cur_ch2),
        .xfer_cnt(xfer2), .skip_cnt(skip2));

    // Device model for the 3-channel instance
    int          ready_after[NCH];
    logic [7:0]  data_mem[NCH];
    int          dev_polls[NCH];
    int          dev_ch;
    logic [7:0]  dev_val;

    always_comb begin
        dev_ch  = 0;
        dev_val = 8'h00;
        if (addr >= 16'h0100 && addr < 16'h0100 + 16'(2 * NCH)) begin
            dev_ch = int'((addr - 16'h0100) >> 1);
            if (addr[0] == 1'b0) dev_val = (dev_polls[dev_ch] > ready_after[dev_ch]) ? 8'h01 : 8'hFE;
            else dev_val = data_mem[dev_ch];
        end
    end

    pullup (data);
    assign data = (ior_ == 1'b0) ? dev_val : 8'bzzzzzzzz;

    int polls2 = 0;
    pullup (data2);
    assign data2 = (ior2_ == 1'b0) ? (addr2[0] ? 8'hFF : ((polls2 > 20) ? 8'h01 : 8'h00)) : 8'bzzzzzzzz;

    // Bus monitors
    logic [15:0] rd_log[$];
    logic [23:0] wr_log[$];
    int          ior_len[$];
    int          iow_len[$];
    int          ior_run = 0, iow_run = 0, busy_cycles = 0;
    logic [23:0] wr2_log[$];
    int          ior2_run = 0, stat2_reads = 0;

    always @(negedge clock) begin
        if (ior_ === 1'b0) begin
            if (ior_run == 0) begin
                rd_log.push_back(addr);
                if (addr >= 16'h0100 && addr < 16'h0106 && addr[0] == 1'b0)
                    dev_polls[int'((addr - 16'h0100) >> 1)]++;
            end
            ior_run++;
        end else if (ior_run != 0) begin
            ior_len.push_back(ior_run);
            ior_run = 0;
        end
        if (iow_ === 1'b0) begin
            if (iow_run == 0) wr_log.push_back({addr, data});
            iow_run++;
        end else if (iow_run != 0) begin
            iow_len.push_back(iow_run);
            iow_run = 0;
        end
        if (busy === 1'b1) busy_cycles++;
        if (ior2_ === 1'b0) begin
            if (ior2_run == 0 && addr2 == 16'h0100) begin
                polls2++;
                stat2_reads++;
            end
            ior2_run++;
        end else begin
            ior2_run = 0;
        end
        if (iow2_ === 1'b0) wr2_log.push_back({addr2, data2});
    end

    // Reference model state
    logic [15:0] exp_rd[$];
    logic [23:0] exp_wr[$];
    int          m_ch = 0, exp_xfer = 0, exp_skip = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete(); ior_len.delete(); iow_len.delete();
    endtask

    // Expected bus traffic for n channels serviced from the model's channel
    task automatic build_expect(input int n);
        exp_rd.delete();
        exp_wr.delete();
        for (int s = 0; s < n; s++) begin
            int c = (m_ch + s) % NCH;
            int polls = (ready_after[c] >= MAX_POLL) ? MAX_POLL : ready_after[c] + 1;
            for (int p = 0; p < polls; p++) exp_rd.push_back(16'(16'h0100 + 2 * c));
            if (ready_after[c] >= MAX_POLL) begin
                exp_skip++;
            end else begin
                int pr = (int'(data_mem[c]) * K) % 65536;
                exp_rd.push_back(16'(16'h0101 + 2 * c));
                exp_wr.push_back({16'(16'h0121 + c), 8'(pr / 256)});
                exp_wr.push_back({16'(16'h0121 + c), 8'(pr % 256)});
                exp_xfer++;
            end
        end
        m_ch = (m_ch + n) % NCH;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy !== 1'b0 && g < 3000) begin @(negedge clock); g++; end
        chk({tag, "_idle_timeout"}, 32'(g < 3000), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nreads"}, 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            chk({tag, "_rdaddr"}, 32'(rd_log[i]), 32'(exp_rd[i]));
        chk({tag, "_nwrites"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            chk({tag, "_write"}, 32'(wr_log[i]), 32'(exp_wr[i]));
        chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'(exp_xfer));
        chk({tag, "_skip_cnt"}, 32'(skip_cnt), 32'(exp_skip));
        chk({tag, "_cur_ch"}, 32'(cur_ch), 32'(m_ch));
        foreach (ior_len[i]) chk({tag, "_ior_width"}, 32'(ior_len[i]), 32'd2);
        foreach (iow_len[i]) chk({tag, "_iow_width"}, 32'(iow_len[i]), 32'd1);
    endtask

    task automatic run_round(input int n, input string tag);
        int prev;
        int g;
        clear_logs();
        for (int c = 0; c < NCH; c++) dev_polls[c] = 0;
        busy_cycles = 0;
        build_expect(n);
        en = 1'b1;
        @(negedge clock);
        for (int s = 1; s < n; s++) begin
            prev = int'(cur_ch);
            g = 0;
            while (int'(cur_ch) == prev && g < 500) begin @(negedge clock); g++; end
            chk({tag, "_advance_timeout"}, 32'(g < 500), 32'd1);
        end
        en = 1'b0;
        wait_idle(tag);
        check_logs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ior"}, 32'(ior_), 32'd1);
        chk({tag, "_iow"}, 32'(iow_), 32'd1);
        chk({tag, "_data_released"}, 32'(data), 32'hFF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cur_ch"}, 32'(cur_ch), 32'd0);
        chk({tag, "_xfer"}, 32'(xfer_cnt), 32'd0);
        chk({tag, "_skip"}, 32'(skip_cnt), 32'd0);
    endtask

    initial begin
        int g;
        for (int c = 0; c < NCH; c++) begin
            ready_after[c] = 0; dev_polls[c] = 0; data_mem[c] = 8'h33;
        end

        // Power-on reset
        repeat (3) @(negedge clock);
        check_reset_state("rst");
        chk("rst_addr", 32'(addr), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Reset while the read strobe is in its first clock
        en = 1'b1;
        g = 0;
        while (ior_ !== 1'b0 && g < 100) begin @(negedge clock); g++; end
        chk("rstb1_reach", 32'(g < 100), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("rst_rstb1");
        reset = 1'b0;
        g = 0;
        while (ior_ !== 1'b0 && g < 100) begin @(negedge clock); g++; end
        chk("restart_status_addr", 32'(addr), 32'h0100);

        // Reset while the write strobe is low
        g = 0;
        while (iow_ !== 1'b0 && g < 100) begin @(negedge clock); g++; end
        chk("wstb_reach", 32'(g < 100), 32'd1);
        reset = 1'b1;
        en = 1'b0;
        @(negedge clock);
        check_reset_state("rst_wstb");
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Directed channel services
        data_mem[0] = 8'h33;
        run_round(1, "ch0_33");
        chk("ch0_33_busy_clocks", 32'(busy_cycles), 32'd16);
        data_mem[1] = 8'hFF;
        run_round(1, "ch1_ff");
        data_mem[2] = 8'h80; ready_after[2] = 2;
        run_round(1, "ch2_poll_wrap");
        data_mem[0] = 8'h01; data_mem[1] = 8'h02; data_mem[2] = 8'h03;
        for (int c = 0; c < NCH; c++) ready_after[c] = 0;
        run_round(3, "three_ch");
        ready_after[0] = 100; ready_after[1] = 0; data_mem[1] = 8'h10;
        run_round(2, "timeout_skip");

        // Randomised rounds
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) begin
                data_mem[c]    = 8'($urandom_range(0, 255));
                ready_after[c] = int'($urandom_range(0, 5));
            end
            run_round(3, "rand");
        end

        // Enable dropped during the data read
        clear_logs();
        for (int c = 0; c < NCH; c++) dev_polls[c] = 0;
        data_mem[m_ch] = 8'hC3; ready_after[m_ch] = 1;
        begin
            logic [15:0] daddr;
            daddr = 16'(16'h0101 + 2 * m_ch);
            build_expect(1);
            en = 1'b1;
            g = 0;
            while (!(ior_ === 1'b0 && addr === daddr) && g < 200) begin @(negedge clock); g++; end
            chk("endrop_data_read_reach", 32'(g < 200), 32'd1);
            en = 1'b0;
        end
        wait_idle("endrop");
        check_logs("endrop");
        clear_logs();
        repeat (20) @(negedge clock);
        chk("endrop_quiet_reads", 32'(rd_log.size()), 32'd0);
        chk("endrop_quiet_writes", 32'(wr_log.size()), 32'd0);
        chk("endrop_busy", 32'(busy), 32'd0);

        // K=255, never-skip instance
        en2 = 1'b1;
        @(negedge clock);
        en2 = 1'b0;
        g = 0;
        while (busy2 !== 1'b0 && g < 3000) begin @(negedge clock); g++; end
        chk("k255_idle_timeout", 32'(g < 3000), 32'd1);
        chk("k255_nwrites", 32'(wr2_log.size()), 32'd2);
        if (wr2_log.size() >= 2) begin
            chk("k255_word_hi", 32'(wr2_log[0]), 32'h0121FE);
            chk("k255_word_lo", 32'(wr2_log[1]), 32'h012101);
        end
        chk("k255_status_reads", 32'(stat2_reads), 32'd21);
        chk("k255_xfer", 32'(xfer2), 32'd1);
        chk("k255_skip", 32'(skip2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
